// File: rtl/ctrl_mc.sv
// ctrl_mc: multi-cycle control FSM for the RV32 datapath.
//
// Sequences fetch, IR load, decode, execute, memory access and writeback,
// driving every enable of the IR/RAM/PC/regfile/ALU. RAM accesses are
// stretched by RAM_WAIT extra cycles, MUL/DIV wait on alu_done, and any
// unsupported encoding produces a one-cycle illegal pulse before the
// next fetch.
//
// Ports
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   instr         IR contents, valid from DECODE onward
//   alu_done      multi-cycle ALU result ready (looked at only in MWAIT)
//   ram_cs/we/oe  RAM strobes; addr_sel chooses PC (0) or ALU result (1)
//   pc_en         PC advance strobe (first FETCH cycle only)
//   pc_in_dir     PC input select, tied 0
//   pc_sign       tied 0
//   ir_en         IR load
//   reg_en/reg_we regfile enable/write; reg_in_dir 00=ALU, 01=RAM data
//   alu_en        ALU enable, alu_op operation code, op2_dir operand-2 source
//   illegal       one-cycle pulse on an unsupported instruction
//   dbg_state_o   current FSM state, for observation only
//
// Handshake: alu_done is a level that the controller samples on each
// rising edge while in MWAIT; the first edge that sees it high ends the
// multi-cycle operation. There is no timeout.

module ctrl_mc #(
    parameter int ALU_OP_W  = 8,
    parameter int RAM_WAIT  = 0,
    parameter int EN_MULDIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                alu_done,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_oe,
    output logic                addr_sel,
    output logic                pc_en,
    output logic                pc_in_dir,
    output logic                pc_sign,
    output logic                ir_en,
    output logic                reg_en,
    output logic                reg_we,
    output logic [1:0]          reg_in_dir,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                illegal,
    output logic [3:0]          dbg_state_o
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_IRLD   = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_MWAIT  = 4'd5,
        S_MRD    = 4'd6,
        S_MWR    = 4'd7,
        S_WB     = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        CL_ALU    = 2'd0,
        CL_MULDIV = 2'd1,
        CL_LW     = 2'd2,
        CL_SW     = 2'd3
    } class_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_ADDI = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_DIV  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_LUI  = ALU_OP_W'(11);

    localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT);

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic [ALU_OP_W-1:0]   op_q, op_d;
    logic [1:0]            o2_q, o2_d;
    class_t                cl_q, cl_d;

    // Combinational decode of the IR, consumed only in DECODE.
    logic [ALU_OP_W-1:0]   dec_op;
    logic [1:0]            dec_o2;
    class_t                dec_cl;
    logic                  dec_ill;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec_op  = OP_ADD;
        dec_o2  = 2'b00;
        dec_cl  = CL_ALU;
        dec_ill = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b101:  dec_op = OP_SRL;
                        3'b100:  dec_op = OP_XOR;
                        3'b110:  dec_op = OP_OR;
                        3'b111:  dec_op = OP_AND;
                        default: dec_ill = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = OP_SUB;
                end else if (funct7 == 7'b0000001 && EN_MULDIV != 0
                             && funct3 == 3'b000) begin
                    dec_op = OP_MUL;
                    dec_cl = CL_MULDIV;
                end else if (funct7 == 7'b0000001 && EN_MULDIV != 0
                             && funct3 == 3'b100) begin
                    dec_op = OP_DIV;
                    dec_cl = CL_MULDIV;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            7'b0010011: begin
                dec_o2 = 2'b10;
                case (funct3)
                    3'b000: dec_op = OP_ADDI;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_op  = OP_SLL;
                        dec_ill = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        dec_op  = OP_SRL;
                        dec_ill = (funct7 != 7'b0000000);
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec_op = OP_LUI;
                dec_o2 = 2'b11;
            end
            7'b0000011: begin
                dec_op  = OP_ADDI;
                dec_o2  = 2'b10;
                dec_cl  = CL_LW;
                dec_ill = (funct3 != 3'b010);
            end
            7'b0100011: begin
                dec_op  = OP_ADDI;
                dec_o2  = 2'b01;
                dec_cl  = CL_SW;
                dec_ill = (funct3 != 3'b010);
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // State register plus the decode latch and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
            wait_q  <= 4'd0;
            op_q    <= '0;
            o2_q    <= 2'b00;
            cl_q    <= CL_ALU;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            o2_q    <= o2_d;
            cl_q    <= cl_d;
        end
    end

    // Next state. wait_d defaults to 0 so the counter is reloaded whenever
    // a RAM-access state is left; it only counts while the state is held.
    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        op_d    = op_q;
        o2_d    = o2_q;
        cl_d    = cl_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
                if (wait_q == WAIT_LAST) state_d = S_IRLD;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_IRLD:  state_d = S_DECODE;
            S_DECODE: begin
                // Latch decode so later IR changes cannot disturb EXEC/MWAIT.
                op_d    = dec_op;
                o2_d    = dec_o2;
                cl_d    = dec_cl;
                state_d = dec_ill ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cl_q)
                    CL_MULDIV: state_d = S_MWAIT;
                    CL_LW:     state_d = S_MRD;
                    CL_SW:     state_d = S_MWR;
                    default:   state_d = S_WB;
                endcase
            end
            S_MWAIT: if (alu_done) state_d = S_WB;
            S_MRD: begin
                if (wait_q == WAIT_LAST) state_d = S_WB;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_MWR: begin
                if (wait_q == WAIT_LAST) state_d = S_FETCH;
                else                     wait_d  = wait_q + 4'd1;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_FETCH;
            default: state_d = S_RST;
        endcase
    end

    // Moore outputs: everything 0 unless the current state asserts it.
    always_comb begin
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_oe     = 1'b0;
        addr_sel   = 1'b0;
        pc_en      = 1'b0;
        pc_in_dir  = 1'b0;
        pc_sign    = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        reg_we     = 1'b0;
        reg_in_dir = 2'b00;
        alu_en     = 1'b0;
        alu_op     = '0;
        op2_dir    = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
                pc_en  = (wait_q == 4'd0);
            end
            S_IRLD:  ir_en = 1'b1;
            S_EXEC, S_MWAIT: begin
                alu_en  = 1'b1;
                alu_op  = op_q;
                op2_dir = o2_q;
            end
            S_MRD: begin
                ram_cs   = 1'b1;
                ram_oe   = 1'b1;
                addr_sel = 1'b1;
            end
            S_MWR: begin
                ram_cs   = 1'b1;
                ram_we   = 1'b1;
                addr_sel = 1'b1;
            end
            S_WB: begin
                reg_en     = 1'b1;
                reg_we     = 1'b1;
                reg_in_dir = (cl_q == CL_LW) ? 2'b01 : 2'b00;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule
